rt_imp_mul_arb: RTL and testbench
=================================

# rt_imp_mul_arb

Round-robin arbiter and sequencer that shares one pipelined 12×12 unsigned multiplier among `NREQ` requesters. Each requester offers operands on a valid/ready port. The block issues at most one product per cycle into the multiplier and carries the requester ID alongside the multiplier latency. Results leave on a single tagged response port with backpressure, which stalls the whole pipeline. The block sits between the HLS-generated compute stages and the shared DSP multiplier.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `IDW`, `$clog2(NREQ)`: width of the requester ID.
- `LAT`, 4: multiplier latency in cycles, from acceptance to result valid. Fixed by the sub-module.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req_valid` in NREQ: per-requester operand valid.
- `req_ready` out NREQ: per-requester accept. One-hot or zero.
- `req_a` in NREQ*12: packed operand A, requester i at bits [12i+11:12i].
- `req_b` in NREQ*12: packed operand B.
- `rsp_valid` out 1: result valid.
- `rsp_ready` in 1: consumer accepts the result.
- `rsp_id` out IDW: requester that owns the result.
- `rsp_p` out 24: unsigned product.

## Operation
- A transfer occurs on requester i when `req_valid[i] && req_ready[i]`.
- Pipeline advance `adv = !(rsp_valid && !rsp_ready)`. The multiplier `ce` equals `adv`.
- Arbitration:
  - Grant goes to the first requester with `req_valid` set, searching from `ptr` upward with wrap-around.
  - `req_ready[g]=1` only when `adv=1`.
  - `req_ready` is combinational from `req_valid`, `ptr` and `adv`. It has no dependency on `req_a` or `req_b`.
- `ptr` update: after a transfer to g, `ptr <= (g+1) mod NREQ`. Otherwise `ptr` holds.
  - Wrap-around case: g=NREQ-1 gives ptr=0.
- Sideband shift register, `LAT` entries of {valid, id}:
  - Shifts only when `adv=1`.
  - Entry 0 loads {transfer, g}.
  - The last entry drives `rsp_valid` and `rsp_id`.
  - Its timing matches the multiplier's `p` output.
- Bubbles occur when no request is valid. They carry valid=0, and the multiplier still clocks.
- A stall freezes all stages, including the operand registers. The held result on `rsp_p` must stay stable.
- Simultaneous events:
  - Incoming request plus a stalled output: no grant, `req_ready` is all 0.
  - Output accepted in the same cycle as a new grant: both happen, and the pipeline shifts once.
- Arithmetic: `rsp_p = req_a*req_b`, zero-extended to 24 bits. It cannot overflow. Example: 4095*4095 = 0xFFE001.

## Timing
- Latency:
  - A transfer at rising edge T gives `rsp_valid=1` in cycle T+LAT-1, counted as whole cycles after T, i.e. the result is visible after the LAT-th edge.
  - Each stall cycle while the result is in flight adds one cycle.
- Throughput: one result per cycle when `rsp_ready` is held high.
- Reset values, applied asynchronously while `reset`=0:
  - All sideband valids are 0, so `rsp_valid=0`.
  - `rsp_id=0`, `ptr=0`.
  - `req_ready=0` while in reset.
  - Multiplier data registers are don't-care, masked by valid.
- Reset asserted mid-operation drops all in-flight results, with no `rsp_valid` pulse. After release, arbitration restarts from requester 0.
- `rsp_valid` must not depend combinationally on `rsp_ready`.

## Configuration
- `RT_IMP_MUL_ARB_STATS_EN` defined:
  - Adds output `grant_cnt`, NREQ*16 bits: per-requester 16-bit transfer counters.
  - Adds output `stall_cnt`, 16 bits: counts cycles with `adv=0`.
  - All counters saturate at 0xFFFF and reset to 0.
- Macro undefined: those ports and counters do not exist. All other behaviour is identical.

## Structure
- Package `rt_imp_mul_arb_pkg`:
  - Constants `MUL_W=12`, `PROD_W=24`, `MUL_LAT=4`.
  - Typedef `mul_op_t` {a,b}.
  - Typedef `mul_tag_t` {valid,id}.
- Sub-module `rt_imp_mul_arb_core`: a 4-stage registered unsigned multiplier with `ce`.
  - Stages: operand register, product register, output register, plus the latency-matching stage.
  - The arbiter instantiates it once.

## Test plan
- Single request: req 2 sends a=3, b=5 with `rsp_ready`=1. Expect `rsp_valid` exactly LAT cycles later with id=2, p=15, and a single-cycle pulse.
- All four requesters continuously valid, `rsp_ready`=1. Grants follow 0,1,2,3,0,…, giving one result per cycle with ids in the same order.
- Max operands: 4095*4095 → p=0xFFE001. 0*4095 → p=0.
- Backpressure: `rsp_ready`=0 for 5 cycles while 3 results are in flight.
  - `rsp_valid` and `rsp_p` hold steady.
  - `req_ready` stays 0.
  - After release, all 3 results arrive in order with no loss or duplication.
- Only req 3 valid with `ptr`=3. It is granted, then `ptr` wraps to 0. Next, reqs 0 and 3 are both valid: req 0 wins.
- Reset pulse during 2 in-flight ops: no `rsp_valid` during reset or after it.
  - The next request from req 1 returns id=1 after LAT cycles.
  - With STATS_EN, the counters read 0 after reset.

Source files
------------

// File: rtl/rt_imp_mul_arb_pkg.sv
// Shared types and constants for the round-robin multiplier arbiter.
// Optional statistics counters are enabled with RT_IMP_MUL_ARB_STATS_EN.
package rt_imp_mul_arb_pkg;

    localparam int MUL_W   = 12;
    localparam int PROD_W  = 24;
    localparam int MUL_LAT = 4;
    // Widest ID needed for the largest supported requester count (8).
    localparam int TAG_IDW = 3;

    typedef struct packed {
        logic [MUL_W-1:0] a;
        logic [MUL_W-1:0] b;
    } mul_op_t;

    typedef struct packed {
        logic               valid;
        logic [TAG_IDW-1:0] id;
    } mul_tag_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/rt_imp_mul_arb_if.sv
// Requester and tagged-response handshake bundle of the multiplier arbiter.
interface rt_imp_mul_arb_if #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
);
    import rt_imp_mul_arb_pkg::*;

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*MUL_W-1:0] req_a;
    logic [NREQ*MUL_W-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [PROD_W-1:0]     rsp_p;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_p
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_p
    );
endinterface

// File: rtl/rt_imp_mul_arb_core.sv
// Four-stage registered unsigned 12x12 multiplier with a common clock enable.
module rt_imp_mul_arb_core
    import rt_imp_mul_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ce,
    input  mul_op_t           op,
    output logic [PROD_W-1:0] p
);

    mul_op_t           op_r;
    logic [PROD_W-1:0] prod_r;
    logic [PROD_W-1:0] out_r;
    logic [PROD_W-1:0] p_r;

    // Operand, product, output and latency-matching stages; all freeze when ce is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r   <= '0;
            prod_r <= {PROD_W{1'b0}};
            out_r  <= {PROD_W{1'b0}};
            p_r    <= {PROD_W{1'b0}};
        end else if (ce) begin
            op_r   <= op;
            prod_r <= PROD_W'(op_r.a) * PROD_W'(op_r.b);
            out_r  <= prod_r;
            p_r    <= out_r;
        end
    end

    assign p = p_r;

endmodule

// File: rtl/rt_imp_mul_arb.sv
// Round-robin arbiter sharing one pipelined multiplier among NREQ requesters.
// Defining RT_IMP_MUL_ARB_STATS_EN adds saturating grant and stall counters.
module rt_imp_mul_arb
    import rt_imp_mul_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    rt_imp_mul_arb_if.slave      bus
`ifdef RT_IMP_MUL_ARB_STATS_EN
    ,
    output logic [NREQ*16-1:0]   grant_cnt,
    output logic [15:0]          stall_cnt
`endif
);

    localparam int LAT = MUL_LAT;

    logic           adv_s;
    logic           grant_valid_s;
    logic [IDW-1:0] grant_id_s;
    logic           xfer_s;
    logic [IDW-1:0] ptr_r;
    mul_op_t        op_s;
    mul_tag_t       tag_r [LAT];

    assign adv_s = !(bus.rsp_valid && !bus.rsp_ready);

    // First valid requester at or after ptr, wrapping around.
    always_comb begin
        int  idx;
        logic hit;
        grant_valid_s = 1'b0;
        grant_id_s    = {IDW{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            idx           = int'(ptr_r) + k;
            idx           = (idx >= NREQ) ? idx - NREQ : idx;
            hit           = !grant_valid_s && bus.req_valid[idx];
            grant_id_s    = hit ? IDW'(idx) : grant_id_s;
            grant_valid_s = grant_valid_s | hit;
        end
    end

    // Holding reset low also blocks acceptance, since adv alone would be high then.
    assign xfer_s        = grant_valid_s && adv_s && reset;
    assign bus.req_ready = xfer_s ? ({{(NREQ-1){1'b0}}, 1'b1} << grant_id_s) : {NREQ{1'b0}};

    assign op_s.a = bus.req_a[grant_id_s*MUL_W +: MUL_W];
    assign op_s.b = bus.req_b[grant_id_s*MUL_W +: MUL_W];

    // Round-robin pointer moves past the requester just served.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_r <= {IDW{1'b0}};
        end else if (xfer_s) begin
            ptr_r <= (grant_id_s == IDW'(NREQ-1)) ? {IDW{1'b0}} : grant_id_s + IDW'(1);
        end
    end

    // Sideband {valid,id} travels in lockstep with the multiplier stages.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LAT; i++) begin
                tag_r[i] <= '0;
            end
        end else if (adv_s) begin
            tag_r[0] <= {xfer_s, TAG_IDW'(grant_id_s)};
            for (int i = 1; i < LAT; i++) begin
                tag_r[i] <= tag_r[i-1];
            end
        end
    end

    rt_imp_mul_arb_core u_core (
        .clk   (clk),
        .rst_n (reset),
        .ce    (adv_s),
        .op    (op_s),
        .p     (bus.rsp_p)
    );

    assign bus.rsp_valid = tag_r[LAT-1].valid;
    assign bus.rsp_id    = tag_r[LAT-1].id[IDW-1:0];

`ifdef RT_IMP_MUL_ARB_STATS_EN
    logic [NREQ*16-1:0] grant_cnt_r;
    logic [15:0]        stall_cnt_r;

    // Saturating per-requester grant counters and stall-cycle counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_cnt_r <= {(NREQ*16){1'b0}};
            stall_cnt_r <= 16'd0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (xfer_s && (grant_id_s == IDW'(i))) begin
                    grant_cnt_r[i*16 +: 16] <= sat_inc16(grant_cnt_r[i*16 +: 16]);
                end
            end
            if (!adv_s) begin
                stall_cnt_r <= sat_inc16(stall_cnt_r);
            end
        end
    end

    assign grant_cnt = grant_cnt_r;
    assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_rt_imp_mul_arb.sv
// Directed self-checking bench for rt_imp_mul_arb with an in-order response scoreboard.
module tb_rt_imp_mul_arb;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [23:0]    p;
    } exp_t;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_err;
    exp_t exp_q[$];

    rt_imp_mul_arb_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

`ifdef RT_IMP_MUL_ARB_STATS_EN
    logic [NREQ*16-1:0] grant_cnt;
    logic [15:0]        stall_cnt;
`endif

    rt_imp_mul_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
`ifdef RT_IMP_MUL_ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [11:0] a, input logic [11:0] b);
        bus.req_valid[i]       = 1'b1;
        bus.req_a[i*12 +: 12]  = a;
        bus.req_b[i*12 +: 12]  = b;
    endtask

    task automatic push(input int id, input logic [23:0] p);
        exp_q.push_back({IDW'(id), p});
    endtask

    // Scoreboard: every accepted response must match the next expected one.
    always @(negedge clk) begin
        if (reset && bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexp_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_id", 32'(bus.rsp_id), 32'(e.id));
                chk("rsp_p", 32'(bus.rsp_p), 32'(e.p));
            end
        end
    end

    initial begin
        logic [23:0] sprod [4];
        int w;
        sprod[0] = 24'd700;  sprod[1] = 24'd1600;
        sprod[2] = 24'd2700; sprod[3] = 24'd4000;
        n_chk = 0;
        n_err = 0;
        reset = 1'b0;
        bus.req_valid = 4'hF;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.rsp_ready = 1'b1;

        // Reset state, with requests pending
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_id", 32'(bus.rsp_id), 32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        step();
        reset = 1'b1;
        bus.req_valid = 4'h0;
        step();

        // Single request, latency and pulse width
        set_req(2, 12'd3, 12'd5);
        push(2, 24'd15);
        @(negedge clk); chk("single_ready", 32'(bus.req_ready), 32'h4);
        step();
        bus.req_valid = 4'h0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); chk("single_lat", 32'(bus.rsp_valid), (k == 3) ? 32'd1 : 32'd0);
            step();
        end

        // Pointer at 3: wrap to 0, then 0 beats 3
        set_req(3, 12'd4095, 12'd4095);
        push(3, 24'hFFE001);
        @(negedge clk); chk("wrap_ready3", 32'(bus.req_ready), 32'h8);
        step();
        set_req(0, 12'd0, 12'd4095);
        set_req(3, 12'd7, 12'd9);
        push(0, 24'd0);
        @(negedge clk); chk("wrap_ready0", 32'(bus.req_ready), 32'h1);
        step();
        bus.req_valid[0] = 1'b0;
        push(3, 24'd63);
        @(negedge clk); chk("wrap_ready3b", 32'(bus.req_ready), 32'h8);
        step();
        bus.req_valid = 4'h0;

        // All requesters streaming
        for (int i = 0; i < 4; i++) set_req(i, 12'(100 * (i + 1)), 12'(i + 7));
        for (int k = 0; k < 8; k++) begin
            push(k % 4, sprod[k % 4]);
            @(negedge clk); chk("stream_ready", 32'(bus.req_ready), 32'(1 << (k % 4)));
            step();
        end
        bus.req_valid = 4'h0;
        repeat (5) step();

        // Backpressure with three results in flight
        set_req(0, 12'd11, 12'd13);
        set_req(1, 12'd17, 12'd19);
        set_req(2, 12'd4095, 12'd1);
        push(0, 24'd143);
        @(negedge clk); chk("bp_ready0", 32'(bus.req_ready), 32'h1);
        step();
        bus.req_valid[0] = 1'b0;
        push(1, 24'd323);
        @(negedge clk); chk("bp_ready1", 32'(bus.req_ready), 32'h2);
        step();
        bus.req_valid[1] = 1'b0;
        push(2, 24'd4095);
        @(negedge clk); chk("bp_ready2", 32'(bus.req_ready), 32'h4);
        step();
        bus.req_valid = 4'h0;
        bus.rsp_ready = 1'b0;
        step();
        set_req(3, 12'd2, 12'd3);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_p", 32'(bus.rsp_p), 32'd143);
            chk("bp_id", 32'(bus.rsp_id), 32'd0);
            chk("bp_ready", 32'(bus.req_ready), 32'd0);
            step();
        end
        bus.rsp_ready = 1'b1;
        push(3, 24'd6);
        @(negedge clk); chk("bp_release_ready", 32'(bus.req_ready), 32'h8);
        step();
        bus.req_valid = 4'h0;
        repeat (6) step();
`ifdef RT_IMP_MUL_ARB_STATS_EN
        @(negedge clk); chk("stall_cnt", 32'(stall_cnt), 32'd5);
`endif

        // Reset with two operations in flight
        set_req(0, 12'd5, 12'd5);
        set_req(1, 12'd6, 12'd6);
        step();
        step();
        bus.req_valid = 4'h0;
        step();
        reset = 1'b0;
        @(negedge clk); chk("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
        step();
        @(negedge clk); chk("mid_rst_valid2", 32'(bus.rsp_valid), 32'd0);
        step();
        reset = 1'b1;
`ifdef RT_IMP_MUL_ARB_STATS_EN
        @(negedge clk);
        chk("rst_grant_cnt", 32'(|grant_cnt), 32'd0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); chk("post_rst_valid", 32'(bus.rsp_valid), 32'd0);
            step();
        end
        set_req(1, 12'd9, 12'd9);
        set_req(3, 12'd2, 12'd2);
        push(1, 24'd81);
        @(negedge clk); chk("post_rst_ready", 32'(bus.req_ready), 32'h2);
        step();
        bus.req_valid = 4'h0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); chk("post_rst_lat", 32'(bus.rsp_valid), (k == 3) ? 32'd1 : 32'd0);
            step();
        end
`ifdef RT_IMP_MUL_ARB_STATS_EN
        @(negedge clk); chk("grant_cnt1", 32'(grant_cnt[16 +: 16]), 32'd1);
`endif

        w = 0;
        while (exp_q.size() != 0 && w < 50) begin
            step();
            w++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
